// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: turns debounced key presses into one-cycle write strobes
// for the four operand digit memories, and sequences a four-strobe clear of all slots.
module keypad_entry_ctrl #(
    parameter logic [3:0] NEXT_CODE  = 4'hA,
    parameter logic [3:0] CLEAR_CODE = 4'hF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_pressed,
    input  logic [3:0] key_code,
    output logic [3:0] digit,
    output logic [3:0] sel,
    output logic [1:0] entry_pos,
    output logic       entry_done,
    output logic       busy
);

    typedef enum logic [3:0] {
        ENT_L1, ENT_L0, ENT_R1, ENT_R0, FULL, CLR0, CLR1, CLR2, CLR3
    } state_t;

    state_t     state, state_n;
    logic       prev_key;
    logic       press;
    logic [3:0] digit_n;
    logic [3:0] sel_n;
    logic [1:0] pos_n;
    logic       done_n;
    logic       busy_n;

    // prev_key resets high so a key held across reset release is not a press
    assign press = key_pressed & ~prev_key;

    always_comb begin
        state_n = state;
        digit_n = digit;
        sel_n   = 4'b0000;
        pos_n   = 2'd0;
        done_n  = 1'b0;
        busy_n  = 1'b0;

        case (state)
            ENT_L1, ENT_L0, ENT_R1, ENT_R0: begin
                if (press) begin
                    if (key_code == CLEAR_CODE) begin
                        state_n = CLR0;
                    end else if (key_code == NEXT_CODE) begin
                        if (state == ENT_L1 || state == ENT_L0)
                            state_n = ENT_R1;
                    end else if (key_code <= 4'd9) begin
                        digit_n = key_code;
                        sel_n   = 4'b0001 << entry_pos;
                        case (state)
                            ENT_L1:  state_n = ENT_L0;
                            ENT_L0:  state_n = ENT_R1;
                            ENT_R1:  state_n = ENT_R0;
                            default: state_n = FULL;
                        endcase
                    end
                end
            end
            FULL: begin
                if (press && key_code == CLEAR_CODE)
                    state_n = CLR0;
            end
            CLR0:    state_n = CLR1;
            CLR1:    state_n = CLR2;
            CLR2:    state_n = CLR3;
            CLR3:    state_n = ENT_L1;
            default: state_n = ENT_L1;
        endcase

        // Outputs are registered, so they are derived from the state being entered
        case (state_n)
            ENT_L1: pos_n = 2'd0;
            ENT_L0: pos_n = 2'd1;
            ENT_R1: pos_n = 2'd2;
            ENT_R0: pos_n = 2'd3;
            FULL: begin
                pos_n  = 2'd3;
                done_n = 1'b1;
            end
            CLR0: begin
                sel_n   = 4'b0001;
                digit_n = 4'd0;
                busy_n  = 1'b1;
            end
            CLR1: begin
                sel_n   = 4'b0010;
                digit_n = 4'd0;
                busy_n  = 1'b1;
            end
            CLR2: begin
                sel_n   = 4'b0100;
                digit_n = 4'd0;
                busy_n  = 1'b1;
            end
            CLR3: begin
                sel_n   = 4'b1000;
                digit_n = 4'd0;
                busy_n  = 1'b1;
            end
            default: pos_n = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ENT_L1;
            prev_key   <= 1'b1;
            digit      <= 4'd0;
            sel        <= 4'b0000;
            entry_pos  <= 2'd0;
            entry_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            prev_key   <= key_pressed;
            digit      <= digit_n;
            sel        <= sel_n;
            entry_pos  <= pos_n;
            entry_done <= done_n;
            busy       <= busy_n;
        end
    end

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Self-checking bench for keypad_entry_ctrl: directed scenarios plus random key traffic,
// every cycle compared against a slot-counter reference model.
module tb_keypad_entry_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_pressed = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic [3:0] digit;
    logic [3:0] sel;
    logic [1:0] entry_pos;
    logic       entry_done;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // reference model state
    int m_pos;
    bit m_full;
    int m_clr;
    bit m_prev;
    int m_digit;
    int m_sel;

    keypad_entry_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .key_pressed(key_pressed),
        .key_code   (key_code),
        .digit      (digit),
        .sel        (sel),
        .entry_pos  (entry_pos),
        .entry_done (entry_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // m_clr counts clear strobes already issued (0 = idle)
    function automatic void modelStep(input bit r, input bit kp, input int kc);
        bit press;
        if (r) begin
            m_pos = 0; m_full = 0; m_clr = 0; m_prev = 1; m_digit = 0; m_sel = 0;
            return;
        end
        press  = kp && !m_prev;
        m_prev = kp;
        m_sel  = 0;
        if (m_clr != 0) begin
            if (m_clr < 4) begin
                m_sel   = 1 << m_clr;
                m_digit = 0;
                m_clr++;
            end else begin
                m_clr = 0;
            end
        end else if (press) begin
            if (kc == 15) begin
                m_clr = 1; m_sel = 1; m_digit = 0; m_pos = 0; m_full = 0;
            end else if (m_full) begin
                m_sel = 0;
            end else if (kc == 10) begin
                if (m_pos < 2) m_pos = 2;
            end else if (kc <= 9) begin
                m_sel   = 1 << m_pos;
                m_digit = kc;
                if (m_pos == 3) m_full = 1;
                else m_pos++;
            end
        end
    endfunction

    task automatic applyStimulus(input bit r, input bit kp, input int kc, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            rst         = r;
            key_pressed = kp;
            key_code    = 4'(kc);
            @(posedge clk);
            modelStep(r, kp, kc);
            #1;
            checkOutput("sel", 8'(sel), 8'(m_sel));
            checkOutput("digit", 8'(digit), 8'(m_digit));
            checkOutput("busy", 8'(busy), 8'(m_clr != 0));
            checkOutput("entry_pos", 8'(entry_pos), 8'(m_pos));
            checkOutput("entry_done", 8'(entry_done), 8'(m_full));
        end
    endtask

    task automatic pressKey(input int kc, input int hold, input int gap);
        applyStimulus(0, 1, kc, hold);
        applyStimulus(0, 0, kc, gap);
    endtask

    initial begin
        int code;
        applyStimulus(1, 0, 0, 3);
        applyStimulus(0, 0, 0, 2);

        // fill all four slots, then a fifth digit must be ignored
        pressKey(3, 3, 2);
        pressKey(7, 3, 2);
        pressKey(2, 3, 2);
        pressKey(9, 3, 2);
        pressKey(5, 3, 2);

        // clear from FULL while the key stays held past the end of the clear
        pressKey(15, 8, 2);

        // long hold gives a single write
        pressKey(6, 20, 2);

        // skip to the right operand
        pressKey(15, 1, 6);
        pressKey(4, 2, 2);
        pressKey(10, 2, 2);
        pressKey(8, 2, 2);

        // press during CLR1 must be dropped, then a normal write
        pressKey(15, 1, 1);
        pressKey(5, 2, 4);
        pressKey(1, 2, 2);

        // reset during CLR2 with the key held through reset release
        pressKey(7, 2, 1);
        applyStimulus(0, 1, 15, 3);
        applyStimulus(1, 1, 15, 2);
        applyStimulus(0, 1, 15, 3);
        applyStimulus(0, 0, 0, 2);
        pressKey(2, 2, 2);

        // random traffic with occasional resets
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 9) < 7) code = $urandom_range(0, 9);
            else code = $urandom_range(10, 15);
            if ($urandom_range(0, 29) == 0)
                applyStimulus(1, bit'($urandom_range(0, 1)), code, 1);
            else
                pressKey(code, $urandom_range(1, 4), $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_entry_ctrl.md
Name: keypad_entry_ctrl

Overview:
- Upstream write controller for the four operand digit memories (left1, left0, right1, right0) that feed the display and arithmetic path.
- Takes a debounced key level and key code from the keypad scanner and walks an entry pointer through the four digit slots.
- Drives a shared 4-bit digit bus and a one-hot, single-cycle select strobe that each digit memory decodes.
- Also sequences a four-cycle clear that zeroes all memories through the same bus.

Parameters:
- NEXT_CODE, 4'hA, key code that skips the rest of the left operand and jumps to right1.
- CLEAR_CODE, 4'hF, key code that starts the clear sequence.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- key_pressed  input  1  debounced key-held level from keypad scanner
- key_code  input  4  code of the held key; valid whenever key_pressed=1
- digit  output  4  digit value presented to the memories
- sel  output  4  one-hot write strobe: 4'b0001 left1, 4'b0010 left0, 4'b0100 right1, 4'b1000 right0; 4'b0000 = no write
- entry_pos  output  2  slot the next digit goes to: 0 left1, 1 left0, 2 right1, 3 right0
- entry_done  output  1  all four slots written; further digits ignored
- busy  output  1  clear sequence in progress

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high on rst; it is sampled only on the rising edge of clk.
- All outputs are registered.
- Reset values: digit=0, sel=0, entry_pos=0, entry_done=0, busy=0. FSM goes to ENT_L1. Previous-key register resets to 1, so a key held through reset release never produces a press.
- Press event: key_pressed=1 at a rising edge where the previous sampled value was 0. Exactly one press per assertion, regardless of hold length.
- Latency: for a press sampled at edge k, the resulting sel/digit are visible after edge k and last exactly one cycle. sel returns to 0 after edge k+1.
- digit holds its last value when sel=0.
- FSM states: ENT_L1, ENT_L0, ENT_R1, ENT_R0, FULL, CLR0, CLR1, CLR2, CLR3.
- Digit press (key_code 0..9) in ENT_x:
  - digit<=key_code, sel<=strobe for that slot.
  - Advance ENT_L1->ENT_L0->ENT_R1->ENT_R0->FULL.
  - entry_pos follows the state; in FULL it stays at 3.
- NEXT_CODE press:
  - In ENT_L1 or ENT_L0: go to ENT_R1 with no write; the skipped slots keep their old values.
  - In ENT_R1, ENT_R0 or FULL: ignored.
- CLEAR_CODE press in any ENT_x or FULL state:
  - Enter CLR0; busy=1 for CLR0..CLR3.
  - Each CLR state emits digit=0 with sel 0001, 0010, 0100, 1000 in turn, one per cycle. That is four consecutive strobes starting the cycle after the press edge.
  - After CLR3: ENT_L1, entry_pos=0, entry_done=0, busy=0.
- Press during CLR0..CLR3: ignored and not queued. The edge detector keeps tracking, so a key still held after the clear ends does not fire.
- FULL: entry_done=1; digit presses and NEXT_CODE are ignored; only CLEAR_CODE acts.
- Codes 10..14 other than NEXT_CODE, and code 15 when CLEAR_CODE is redefined: ignored in every state.
- rst=1 mid-clear or mid-entry: the next edge forces the reset values and aborts any remaining clear strobes.
- Invariants:
  - sel is always 0 or one-hot.
  - At most one write per cycle.
  - A write never occurs in FULL.

Test Plan:
- Reset, then press 3,7,2,9 with 3-cycle holds and 2-cycle gaps -> strobes 0001/3, 0010/7, 0100/2, 1000/9, each one cycle long; entry_done=1 after the 4th; a 5th press of 5 yields sel=0.
- Hold key 6 for 20 cycles in ENT_L1 -> exactly one strobe 0001 with digit=6; entry_pos goes 0->1.
- Press 4 then NEXT_CODE then 8 -> strobe 0001/4, no write for NEXT, then strobe 0100/8; entry_pos=3.
- From FULL press CLEAR_CODE and keep it held -> busy=1 for 4 cycles with strobes 0001, 0010, 0100, 1000 (all digit=0), then entry_pos=0 and entry_done=0; no extra press after busy falls.
- Press 5 during CLR1 -> ignored, no strobe; after clear, pressing 1 writes 0001/1.
- Assert rst during CLR2 -> next cycle sel=0, busy=0, entry_pos=0; no CLR3 strobe. With key held through reset release, no press is registered.
